// File: rtl/sha256_arbiter.sv
// sha256_arbiter
// Shares one SHA-256 core between NUM_REQ hash clients. An idle core is
// granted round-robin to a requesting client. That client's 512-bit block is
// captured and presented to the core with an init strobe. The arbiter then
// waits for the digest and returns it, and resets the core for one cycle
// before the next job. A watchdog aborts a job whose digest never arrives.
//
// Ports
//   i_clk              clock
//   i_reset            synchronous active-high reset
//   i_req              level request per client (held until done/timeout)
//   i_req_block        flattened blocks, client i at [512*i+511:512*i]
//   o_gnt              one-hot grant, high while a client owns the core
//   o_done             one-cycle pulse, o_digest valid for that client
//   o_timeout          one-cycle pulse, that client's job was aborted
//   o_digest           last captured digest, held until the next done
//   o_busy             FSM not idle
//   o_sha_init         core init strobe
//   o_sha_reset_n      core reset, active-low
//   o_sha_block        block presented to the core (0 when not owned)
//   i_sha_ready        core idle
//   i_sha_digest       core digest
//   i_sha_digest_valid core digest valid
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner; arbitrate when a request is pending and core is idle
// INIT     | grant asserted, init strobe to the core, watchdog cleared
// WAIT     | grant held, waiting for digest or watchdog limit
// RELEASE  | grant dropped, core held in reset for one cycle

module sha256_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ*512-1:0] i_req_block,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_done,
    output logic [NUM_REQ-1:0]     o_timeout,
    output logic [255:0]           o_digest,
    output logic                   o_busy,
    output logic                   o_sha_init,
    output logic                   o_sha_reset_n,
    output logic [511:0]           o_sha_block,
    input  logic                   i_sha_ready,
    input  logic [255:0]           i_sha_digest,
    input  logic                   i_sha_digest_valid
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    localparam logic [WW-1:0]      WDOG_LIMIT = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0]      LAST_RST   = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE        = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       r_last;
    logic [511:0]        r_blk;
    logic [WW-1:0]       r_wdog;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_timeout;
    logic [255:0]        r_digest;

    logic                w_arb;
    logic                w_wdog_hit;
    logic [IW-1:0]       w_win_idx;
    logic [511:0]        w_sel_block;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [NUM_REQ-1:0]  w_idx_onehot;

    // First set request scanning upward from last+1, wrapping.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IW-1:0]      last);
        logic [IW-1:0] pick;
        logic          found;
        int            c;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(last) + k) % NUM_REQ;
            if (!found && 1'(req >> c)) begin
                found = 1'b1;
                pick  = IW'(c);
            end
        end
        return pick;
    endfunction

    // A stale digest_valid means the core has not been cleaned up yet.
    assign w_arb        = (|i_req) && i_sha_ready && !i_sha_digest_valid;
    assign w_win_idx    = rr_pick(i_req, r_last);
    assign w_sel_block  = 512'(i_req_block >> {w_win_idx, 9'd0});
    assign w_win_onehot = ONE << w_win_idx;
    assign w_idx_onehot = ONE << r_idx;
    assign w_wdog_hit   = (r_wdog == WDOG_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_busy        = 1'b1;
        o_sha_init    = 1'b0;
        o_sha_block   = '0;
        o_sha_reset_n = !i_reset;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_arb) begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                o_sha_init  = 1'b1;
                o_sha_block = r_blk;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                o_sha_block = r_blk;
                if (i_sha_digest_valid || w_wdog_hit) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                o_sha_reset_n = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx     <= '0;
            r_last    <= LAST_RST;
            r_blk     <= '0;
            r_wdog    <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_timeout <= '0;
            r_digest  <= '0;
        end else begin
            r_done    <= '0;
            r_timeout <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb) begin
                        r_idx  <= w_win_idx;
                        r_last <= w_win_idx;
                        r_blk  <= w_sel_block;
                        r_gnt  <= w_win_onehot;
                    end
                end
                ST_INIT: begin
                    r_wdog <= '0;
                end
                ST_WAIT: begin
                    // Digest wins over the watchdog on the same cycle.
                    if (i_sha_digest_valid) begin
                        r_digest <= i_sha_digest;
                        r_done   <= w_idx_onehot;
                        r_gnt    <= '0;
                    end else if (w_wdog_hit) begin
                        r_timeout <= w_idx_onehot;
                        r_gnt     <= '0;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;
    assign o_digest  = r_digest;

endmodule
